// File: rtl/lab62_soc_pio_pkg.sv
// rtl/lab62_soc_pio_pkg.sv - shared register map and FSM encoding for the pulse output block
package lab62_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_PLEN   = 2'd1;
    localparam logic [1:0] ADDR_FIRE   = 2'd2;
    localparam logic [1:0] ADDR_PCOUNT = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/lab62_soc_pulse_timer.sv
// rtl/lab62_soc_pulse_timer.sv - loadable down-counter flagging the last pulse cycle
module lab62_soc_pulse_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        enable,
    output logic        done
);

    logic [15:0] count;

    // Load wins over counting; the count holds at zero so it never underflows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    // A count of one on an active edge marks the final displayed cycle of the pulse.
    assign done = enable && (count == 16'd1);

endmodule

// File: rtl/lab62_soc_pulse_out.sv
// rtl/lab62_soc_pulse_out.sv - Avalon-MM output port with timed one-shot pattern pulses
module lab62_soc_pulse_out
    import lab62_soc_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

    pulse_state_t     state;
    pulse_state_t     state_next;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pattern;
    logic [15:0]      plen;
    logic [7:0]       pcount;
    logic             fire_accept;
    logic             timer_done;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] pattern_next;
    logic [WIDTH-1:0] out_next;
    logic [31:0]      rd_next;

    logic wr_en;
    logic wr_data;
    logic wr_plen;
    logic wr_fire;
    logic wr_pcount;

    assign wr_en     = chipselect && !write_n;
    assign wr_data   = wr_en && (address == ADDR_DATA);
    assign wr_plen   = wr_en && (address == ADDR_PLEN);
    assign wr_fire   = wr_en && (address == ADDR_FIRE);
    assign wr_pcount = wr_en && (address == ADDR_PCOUNT);

    lab62_soc_pulse_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (fire_accept),
        .load_value (plen),
        .enable     (state == ST_PULSE),
        .done       (timer_done)
    );

    // State register; reset aborts any pulse in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fires only start from idle with a non-zero length; the timer ends the pulse.
    always_comb begin
        state_next  = state;
        fire_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_fire && (plen != 16'd0)) begin
                    fire_accept = 1'b1;
                    state_next  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output value for the next cycle is chosen from the post-edge state, so out_port stays a pure flop.
    always_comb begin
        data_next    = wr_data ? writedata[WIDTH-1:0] : data;
        pattern_next = fire_accept ? writedata[WIDTH-1:0] : pattern;
        out_next     = (state_next == ST_PULSE) ? pattern_next : data_next;
    end

    // Read mux from the pre-edge register contents; unused bits stay zero.
    always_comb begin
        rd_next = 32'd0;
        case (address)
            ADDR_DATA:   rd_next[WIDTH-1:0] = data;
            ADDR_PLEN:   rd_next[15:0]      = plen;
            ADDR_FIRE:   rd_next[0]         = (state == ST_PULSE);
            ADDR_PCOUNT: rd_next[7:0]       = pcount;
            default:     rd_next            = 32'd0;
        endcase
    end

    // Bus-visible registers; a PCOUNT clear overrides a completion on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RST_DATA;
            pattern  <= '0;
            plen     <= 16'd0;
            pcount   <= 8'd0;
            out_port <= RST_DATA;
            readdata <= 32'd0;
        end else begin
            data     <= data_next;
            pattern  <= pattern_next;
            out_port <= out_next;
            readdata <= rd_next;
            if (wr_plen) begin
                plen <= writedata[15:0];
            end
            if (wr_pcount) begin
                pcount <= 8'd0;
            end else if (timer_done) begin
                pcount <= pcount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lab62_soc_pulse_out.sv
// tb/tb_lab62_soc_pulse_out.sv - randomized model-checked bench for lab62_soc_pulse_out
module tb_lab62_soc_pulse_out;

    localparam logic [7:0] RV = 8'h5A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    // Reference model: pulse progress kept as a count of cycles still to display.
    int          m_rem;
    logic [7:0]  m_pat;
    logic [7:0]  m_data;
    logic [15:0] m_plen;
    int          m_pc;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
    logic [31:0] m_rd;
    logic        m_wr;

    lab62_soc_pulse_out #(.WIDTH(8), .RESET_VALUE(32'h5A)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem = 0; m_pat = 8'h00; m_data = RV; m_plen = 16'd0; m_pc = 0;
            exp_out = RV; exp_rd = 32'd0;
        end else begin
            case (address)
                2'd0: m_rd = {24'd0, m_data};
                2'd1: m_rd = {16'd0, m_plen};
                2'd2: m_rd = {31'd0, (m_rem > 0)};
                default: m_rd = m_pc;
            endcase
            m_wr = chipselect && !write_n;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_pc = (m_pc + 1) % 256;
            end else if (m_wr && address == 2'd2 && m_plen != 16'd0) begin
                m_rem = m_plen;
                m_pat = writedata[7:0];
            end
            if (m_wr && address == 2'd0) m_data = writedata[7:0];
            if (m_wr && address == 2'd1) m_plen = writedata[15:0];
            if (m_wr && address == 2'd3) m_pc = 0;
            exp_rd  = m_rd;
            exp_out = (m_rem > 0) ? m_pat : m_data;
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (out_port !== exp_out) begin
            errors = errors + 1;
            $display("FAIL model_out t=%0t got %h expected %h", $time, out_port, exp_out);
        end
        checks = checks + 1;
        if (readdata !== exp_rd) begin
            errors = errors + 1;
            $display("FAIL model_rd t=%0t got %h expected %h", $time, readdata, exp_rd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
        chipselect = c; write_n = w; address = a; writedata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input logic [1:0] a);
        bus(1'b0, 1'b1, a, 32'd0);
    endtask

    int n;

    initial begin
        // Reset held with random bus traffic.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            bus($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom);
            chk("rst_out", {24'd0, out_port}, {24'd0, RV});
            chk("rst_rd", readdata, 32'd0);
        end
        reset_n = 1'b1;
        idle(2'd0); idle(2'd0); chk("rst_data", readdata, 32'h5A);
        idle(2'd1); chk("rst_plen", readdata, 32'd0);
        idle(2'd2); chk("rst_status", readdata, 32'd0);
        idle(2'd3); chk("rst_pcount", readdata, 32'd0);

        // Basic pulse.
        wr(2'd0, 32'h0F); wr(2'd1, 32'd3);
        wr(2'd2, 32'hA5); chk("basic_c1", {24'd0, out_port}, 32'hA5);
        idle(2'd2);       chk("basic_c2", {24'd0, out_port}, 32'hA5);
        idle(2'd2);       chk("basic_c3", {24'd0, out_port}, 32'hA5);
        chk("basic_busy", readdata, 32'd1);
        idle(2'd3);       chk("basic_end", {24'd0, out_port}, 32'h0F);
        idle(2'd3);       chk("basic_pcount", readdata, 32'd1);

        // Async reset in the second cycle of a 5-cycle pulse.
        wr(2'd1, 32'd5); wr(2'd2, 32'hC3); idle(2'd2);
        chk("ar_before", {24'd0, out_port}, 32'hC3);
        #2 reset_n = 1'b0;
        #1 chk("ar_out", {24'd0, out_port}, {24'd0, RV});
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2'd2); idle(2'd3); chk("ar_busy", readdata, 32'd0);
        idle(2'd3); chk("ar_pcount", readdata, 32'd0);

        // Ignored fires: zero length, then a retrigger attempt mid-pulse.
        wr(2'd0, 32'h0F); wr(2'd1, 32'd0); wr(2'd2, 32'hFF);
        chk("zero_len_out", {24'd0, out_port}, 32'h0F);
        idle(2'd3); idle(2'd3); chk("zero_len_pc", readdata, 32'd0);
        wr(2'd1, 32'd10);
        wr(2'd2, 32'h11); n = (out_port == 8'h11) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin idle(2'd0); n += (out_port == 8'h11) ? 1 : 0; end
        wr(2'd2, 32'h22); n += (out_port == 8'h11) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin idle(2'd0); n += (out_port == 8'h11) ? 1 : 0; end
        chk("retrig_len", n, 32'd10);

        // DATA write mid-pulse shows in the first idle cycle.
        wr(2'd1, 32'd4); wr(2'd2, 32'h77); wr(2'd0, 32'h33);
        chk("mid_c2", {24'd0, out_port}, 32'h77);
        idle(2'd0); chk("mid_c3", {24'd0, out_port}, 32'h77);
        idle(2'd0); chk("mid_c4", {24'd0, out_port}, 32'h77);
        idle(2'd0); chk("mid_idle", {24'd0, out_port}, 32'h33);

        // PCOUNT clear on the completion edge.
        wr(2'd1, 32'd2); wr(2'd2, 32'h44); idle(2'd0); wr(2'd3, 32'd0);
        idle(2'd3); idle(2'd3); chk("clr_wins", readdata, 32'd0);

        // 256 single-cycle pulses wrap PCOUNT.
        wr(2'd1, 32'd1);
        for (int i = 0; i < 256; i++) begin
            wr(2'd2, 32'hE1 ^ i);
            chk("w1_out", {24'd0, out_port}, 32'hE1 ^ i);
            idle(2'd0);
            chk("w1_end", {24'd0, out_port}, 32'h33);
        end
        idle(2'd3); idle(2'd3); chk("wrap_pc", readdata, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            if (a == 2'd3 && $urandom_range(0, 7) != 0) bus(1'b0, 1'b1, a, d);
            else bus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, d);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
